// File: rtl/cl_seq_divider.sv
// Sequential carry-less (GF(2)[x]) long divider: dividend = quotient*divisor ^ remainder.
// Optional build macro CL_DIV_RADIX4_EN retires two dividend bits per CALC cycle.
module cl_seq_divider #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [2*DATA_WIDTH-1:0]   dividend,
  input  logic [DATA_WIDTH:0]       divisor,
  output logic                      busy,
  output logic                      done,
  output logic                      div_by_zero,
  output logic [2*DATA_WIDTH-1:0]   quotient,
  output logic [DATA_WIDTH-1:0]     remainder
);

  localparam int W  = DATA_WIDTH;
  localparam int QW = 2 * W;
  localparam int CW = $clog2(QW);
  localparam int DW = $clog2(W + 1);
`ifdef CL_DIV_RADIX4_EN
  localparam int STEP = 2;
  localparam logic [CW-1:0] LAST_BIT = CW'(1);
`else
  localparam int STEP = 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(0);
`endif

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state;
  logic [QW-1:0]   dvd_q;
  logic [W:0]      dvs_q;
  logic [DW-1:0]   deg_q;
  logic [W:0]      r_q;
  logic [QW-1:0]   q_acc;
  logic [CW-1:0]   cnt_q;

  logic [W+1:0]    step_hi;
  logic [W:0]      r_next;
  logic [QW-1:0]   q_next;

  function automatic logic [DW-1:0] msb_index(input logic [W:0] v);
    logic [DW-1:0] idx;
    idx = '0;
    for (int i = 0; i <= W; i++) begin
      if (v[i]) idx = DW'(i);
    end
    return idx;
  endfunction

  // One long-division step: shift in a dividend bit, subtract (XOR) divisor when the
  // leading coefficient at the divisor degree is set. Returns {qbit, new partial remainder}.
  function automatic logic [W+1:0] cl_step(input logic [W:0] r, input logic b,
                                           input logic [W:0] d, input logic [DW-1:0] deg);
    logic [W:0] t;
    logic       qb;
    t  = {r[W-1:0], b};
    qb = t[deg];
    if (qb) t = t ^ d;
    return {qb, t};
  endfunction

  always_comb begin
    step_hi = cl_step(r_q, dvd_q[cnt_q], dvs_q, deg_q);
`ifdef CL_DIV_RADIX4_EN
    begin
      logic [W+1:0] step_lo;
      step_lo = cl_step(step_hi[W:0], dvd_q[cnt_q - CW'(1)], dvs_q, deg_q);
      r_next  = step_lo[W:0];
      q_next  = {q_acc[QW-3:0], step_hi[W+1], step_lo[W+1]};
    end
`else
    r_next = step_hi[W:0];
    q_next = {q_acc[QW-2:0], step_hi[W+1]};
`endif
  end

  // Datapath registers: loaded on accept, advanced every CALC cycle.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      dvd_q <= dividend;
      dvs_q <= divisor;
      deg_q <= msb_index(divisor);
      r_q   <= '0;
      cnt_q <= CW'(QW - 1);
    end else if (state == CALC) begin
      r_q   <= r_next;
      q_acc <= q_next;
      cnt_q <= cnt_q - CW'(STEP);
    end
  end

  // Control FSM and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (divisor == '0) begin
              state       <= DONE;
              done        <= 1'b1;
              div_by_zero <= 1'b1;
              quotient    <= '0;
              remainder   <= '0;
            end else begin
              state       <= CALC;
              busy        <= 1'b1;
              div_by_zero <= 1'b0;
            end
          end
        end
        CALC: begin
          if (cnt_q == LAST_BIT) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= q_next;
            remainder <= r_next[W-1:0];
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cl_seq_divider.sv
// Directed and randomized checks of cl_seq_divider at W=8 and W=32.
module tb_cl_seq_divider;

`ifdef CL_DIV_RADIX4_EN
  localparam int LAT8  = 8;
  localparam int LAT32 = 32;
`else
  localparam int LAT8  = 16;
  localparam int LAT32 = 64;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic        start8 = 1'b0;
  logic [15:0] dvd8 = '0;
  logic [8:0]  dvs8 = '0;
  logic        busy8, done8, dbz8;
  logic [15:0] q8;
  logic [7:0]  r8;

  logic        start32 = 1'b0;
  logic [63:0] dvd32 = '0;
  logic [32:0] dvs32 = '0;
  logic        busy32, done32, dbz32;
  logic [63:0] q32;
  logic [31:0] r32;

  int n_total = 0;
  int n_bad   = 0;

  cl_seq_divider #(.DATA_WIDTH(8)) u_div8 (
    .clk(clk), .rst(rst), .start(start8), .dividend(dvd8), .divisor(dvs8),
    .busy(busy8), .done(done8), .div_by_zero(dbz8), .quotient(q8), .remainder(r8)
  );

  cl_seq_divider #(.DATA_WIDTH(32)) u_div32 (
    .clk(clk), .rst(rst), .start(start32), .dividend(dvd32), .divisor(dvs32),
    .busy(busy32), .done(done32), .div_by_zero(dbz32), .quotient(q32), .remainder(r32)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Launch one W=8 operation and check results, latency and busy in cycle 1.
  task automatic test8(input string tag, input logic [15:0] a, input logic [8:0] b,
                       input logic [15:0] eq, input logic [7:0] er, input logic edbz,
                       input int elat);
    int   k;
    logic b1;
    dvd8 = a; dvs8 = b; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    b1 = busy8;
    k  = 0;
    while (!done8 && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    chk({tag, "_lat"}, 64'(k), 64'(elat));
    chk({tag, "_busy1"}, 64'(b1), 64'(elat != 0));
    chk({tag, "_q"}, 64'(q8), 64'(eq));
    chk({tag, "_r"}, 64'(r8), 64'(er));
    chk({tag, "_dbz"}, 64'(dbz8), 64'(edbz));
    @(posedge clk); #1;
    chk({tag, "_done_drop"}, 64'({done8, busy8}), 64'(0));
  endtask

  function automatic logic [96:0] clmul(input logic [63:0] a, input logic [32:0] b);
    logic [96:0] p;
    p = '0;
    for (int i = 0; i <= 32; i++) begin
      if (b[i]) p = p ^ ({33'b0, a} << i);
    end
    return p;
  endfunction

  function automatic int deg33(input logic [32:0] v);
    int d;
    d = -1;
    for (int i = 0; i <= 32; i++) begin
      if (v[i]) d = i;
    end
    return d;
  endfunction

  initial begin
    int nd;
    int k;
    logic drop;
    logic seen;
    logic [96:0] prod;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy8), 64'(0));
    chk("rst_done", 64'(done8), 64'(0));
    chk("rst_dbz", 64'(dbz8), 64'(0));
    chk("rst_q", 64'(q8), 64'(0));
    chk("rst_r", 64'(r8), 64'(0));
    chk("rst_busy32", 64'({busy32, done32}), 64'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    test8("aes",  16'h0100, 9'h11B, 16'h0001, 8'h1B, 1'b0, LAT8);
    test8("one",  16'hABCD, 9'h001, 16'hABCD, 8'h00, 1'b0, LAT8);
    test8("x5",   16'h0005, 9'h003, 16'h0003, 8'h00, 1'b0, LAT8);
    test8("x7",   16'h0007, 9'h003, 16'h0002, 8'h01, 1'b0, LAT8);
    test8("zero", 16'h1234, 9'h000, 16'h0000, 8'h00, 1'b1, 0);

    // start held through the whole op, including the done cycle
    dvd8 = 16'h0007; dvs8 = 9'h003; start8 = 1'b1;
    nd = 0; drop = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      if (drop) start8 = 1'b0;
      if (done8) begin
        nd++;
        drop = 1'b1;
      end
    end
    start8 = 1'b0;
    chk("hold_done_cnt", 64'(nd), 64'(1));
    chk("hold_q", 64'(q8), 64'h0002);
    chk("hold_r", 64'(r8), 64'h01);
    chk("hold_dbz", 64'(dbz8), 64'(0));

    // reset during CALC cycle 5
    dvd8 = 16'hABCD; dvs8 = 9'h11B; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("pre_rst_busy", 64'(busy8), 64'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_busy", 64'(busy8), 64'(0));
    chk("mid_rst_q", 64'(q8), 64'(0));
    chk("mid_rst_r", 64'(r8), 64'(0));
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done8) seen = 1'b1;
    end
    chk("mid_rst_no_done", 64'(seen), 64'(0));

    // randomized W=32 inverse checks
    for (int n = 0; n < 1000; n++) begin
      dvd32 = {$urandom, $urandom};
      dvs32 = {1'($urandom_range(0, 1)), 32'($urandom)} >> $urandom_range(0, 32);
      if (dvs32 == '0) dvs32 = 33'd1;
      start32 = 1'b1;
      @(posedge clk); #1;
      start32 = 1'b0;
      k = 0;
      while (!done32 && k < 200) begin
        @(posedge clk); #1;
        k++;
      end
      if (n < 4) chk("rnd_lat", 64'(k), 64'(LAT32));
      prod = clmul(q32, dvs32) ^ {65'b0, r32};
      chk("rnd_inverse", 64'(prod == {33'b0, dvd32}), 64'(1));
      chk("rnd_deg", 64'(({1'b0, r32} >> deg33(dvs32)) == 33'd0), 64'(1));
      @(posedge clk); #1;
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
